// File: rtl/lag_result_framer_pkg.sv
// Shared types and status-word layout for the lag result framer.
package lag_framer_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE, PUBLISH} state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int FLAG_VALID    = 0;
    localparam int FLAG_FULL     = 1;
    localparam int FLAG_OVERRUN  = 2;
    localparam int FLAG_SAT      = 3;

    localparam int SYNC_OFS  = 56;
    localparam int SEQ_OFS   = 48;
    localparam int FLAGS_OFS = 40;
    localparam int LAG_OFS   = 32;
    localparam int AVG_OFS   = 24;
    localparam int VALUE_OFS = 0;

endpackage

// File: rtl/lag_result_framer_if.sv
// Argmax-result in / status-word out bundle between the argmax stage and the SPI side.
interface lag_result_framer_if #(
    parameter int IDX_W = 8,
    parameter int VAL_W = 32
);
    logic                    frame_done;
    logic [IDX_W-1:0]        max_index;
    logic signed [VAL_W-1:0] max_value;
    logic signed [VAL_W-1:0] min_peak;
    logic [63:0]             word;
    logic                    word_valid;
    logic                    hist_full;
    logic                    overrun;

    modport master (
        output frame_done, max_index, max_value, min_peak,
        input  word, word_valid, hist_full, overrun
    );

    modport slave (
        input  frame_done, max_index, max_value, min_peak,
        output word, word_valid, hist_full, overrun
    );
endinterface

// File: rtl/lag_result_framer_history.sv
// Circular history of signed lags with running sum; push updates in one cycle.
// Latency: sum/full reflect a push on the next clock. No backpressure: push always accepted.
module lag_history #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic signed [W-1:0]              din,
    output logic signed [W+DEPTH_LOG2-1:0]   sum,
    output logic                             full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic signed [W-1:0]            hist [DEPTH];
    logic [DEPTH_LOG2-1:0]          wptr;
    logic [DEPTH_LOG2:0]            fill;
    logic signed [W+DEPTH_LOG2-1:0] din_ext;
    logic signed [W+DEPTH_LOG2-1:0] old_ext;

    assign din_ext = {{DEPTH_LOG2{din[W-1]}}, din};
    assign old_ext = {{DEPTH_LOG2{hist[wptr][W-1]}}, hist[wptr]};
    // fill saturates at DEPTH, so its MSB alone marks a full history
    assign full    = fill[DEPTH_LOG2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wptr <= '0;
            fill <= '0;
            sum  <= '0;
        end else if (push) begin
            hist[wptr] <= din;
            wptr       <= wptr + 1'b1;
            sum        <= sum + din_ext - old_ext;
            if (!fill[DEPTH_LOG2]) fill <= fill + 1'b1;
        end
    end
endmodule

// File: rtl/lag_result_framer.sv
// Frames each argmax result into an atomic 64-bit status word with lag, moving average and flags.
// Latency: 4 clk from frame_done rise to word_valid. No backpressure: rises while busy are dropped and flagged.
module lag_result_framer
    import lag_framer_pkg::*;
#(
    parameter int                      IDX_W    = 8,
    parameter int                      VAL_W    = 32,
    parameter int                      AVG_LOG2 = 3,
    parameter logic signed [VAL_W-1:0] MIN_PEAK = 4096
) (
    input  logic               clk,
    input  logic               rst,
    lag_result_framer_if.slave bus
);
    if (IDX_W > 8) begin : g_idx_check
        $error("lag_result_framer: IDX_W > 8 does not fit the lag field");
    end

    localparam logic signed [VAL_W-1:0] SAT_HI = VAL_W'(24'sh7FFFFF);
    localparam logic signed [VAL_W-1:0] SAT_LO = VAL_W'(24'sh800000);

    state_t                      state;
    logic                        frame_done_q;
    logic                        rise;
    logic signed [VAL_W-1:0]     thr;
    logic signed [IDX_W-1:0]     lag_q;
    logic signed [VAL_W-1:0]     val_q;
    logic                        valid_q;
    logic [7:0]                  seq;
    logic [63:0]                 word;
    logic                        word_valid;
    logic                        overrun;
    logic                        push;
    logic signed [IDX_W+AVG_LOG2-1:0] sum;
    logic                        full;
    logic signed [7:0]           lag_byte;
    logic signed [7:0]           avg_byte;
    logic                        sat_hi;
    logic                        sat_lo;
    logic [23:0]                 value24;
    logic [7:0]                  flags;
    logic [63:0]                 word_nxt;

    assign rise = bus.frame_done & ~frame_done_q;
    assign push = (state == UPDATE) && valid_q;

    lag_history #(.W(IDX_W), .DEPTH_LOG2(AVG_LOG2)) u_hist (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (lag_q),
        .sum  (sum),
        .full (full)
    );

    assign lag_byte = 8'(lag_q);
    assign avg_byte = 8'(sum >>> AVG_LOG2);
    assign sat_hi   = val_q > SAT_HI;
    assign sat_lo   = val_q < SAT_LO;
    assign value24  = sat_hi ? 24'h7FFFFF : (sat_lo ? 24'h800000 : val_q[23:0]);

    always_comb begin
        flags               = '0;
        flags[FLAG_VALID]   = valid_q;
        flags[FLAG_FULL]    = full;
        flags[FLAG_OVERRUN] = overrun;
        flags[FLAG_SAT]     = sat_hi | sat_lo;
        word_nxt                     = '0;
        word_nxt[SYNC_OFS  +: 8]     = SYNC_BYTE;
        word_nxt[SEQ_OFS   +: 8]     = seq;
        word_nxt[FLAGS_OFS +: 8]     = flags;
        word_nxt[LAG_OFS   +: 8]     = lag_byte;
        word_nxt[AVG_OFS   +: 8]     = avg_byte;
        word_nxt[VALUE_OFS +: 24]    = value24;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            frame_done_q <= 1'b0;
            thr          <= MIN_PEAK;
            lag_q        <= '0;
            val_q        <= '0;
            valid_q      <= 1'b0;
            seq          <= '0;
            word         <= '0;
            word_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done_q <= bus.frame_done;
            thr          <= bus.min_peak;
            word_valid   <= 1'b0;
            if (rise && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (rise) state <= CAPTURE;
                CAPTURE: begin
                    // index - 2^(IDX_W-1) in two's complement is just an MSB flip
                    lag_q   <= {~bus.max_index[IDX_W-1], bus.max_index[IDX_W-2:0]};
                    val_q   <= bus.max_value;
                    valid_q <= bus.max_value >= thr;
                    state   <= UPDATE;
                end
                UPDATE: state <= PUBLISH;
                PUBLISH: begin
                    word       <= word_nxt;
                    word_valid <= 1'b1;
                    seq        <= seq + 8'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.word       = word;
    assign bus.word_valid = word_valid;
    assign bus.hist_full  = full;
    assign bus.overrun    = overrun;
endmodule

// File: doc/lag_result_framer.md
Name: lag_result_framer

Overview:
- Downstream of the argmax stage, upstream of the SPI slave.
- Captures each frame's (max index, max value) when the pipeline enters standby and converts the index to a signed lag.
- Applies a peak threshold and keeps a running moving-average of valid lags.
- Publishes one atomic 64-bit status word for the SPI slave, replacing the ad-hoc constant-plus-result word.

Parameters:
IDX_W, 8, width of argmax index; lag = index - 2^(IDX_W-1)
VAL_W, 32, width of argmax max value (signed)
AVG_LOG2, 3, moving average depth = 2^AVG_LOG2 valid frames
MIN_PEAK, 32'sd4096, minimum signed peak for a frame to be valid

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
frame_done  in  1  level; high while all stages are in standby (frame boundary)
max_index  in  IDX_W  argmax index, stable while frame_done high
max_value  in  VAL_W  argmax value (signed), stable while frame_done high
min_peak  in  VAL_W  runtime threshold; loaded at reset to MIN_PEAK when tied to the parameter
word  out  64  published status word
word_valid  out  1  one-cycle pulse when word updates
hist_full  out  1  high once 2^AVG_LOG2 valid frames have been accumulated
overrun  out  1  sticky; a frame_done rising edge arrived while not IDLE

Behaviour:
- Reset (rst low, async): FSM=IDLE, word=64'h0, word_valid=0, hist_full=0, overrun=0, seq=0, history entries=0, running sum=0, frame_done edge register=0.
- Edge detect: frame_done registered once. Rise = frame_done & ~frame_done_q.
- FSM states:
  - IDLE: on rise -> CAPTURE.
  - CAPTURE (1 cycle): latch max_index and max_value.
    - lag_raw = max_index - 2^(IDX_W-1), signed IDX_W bits.
    - valid = (max_value >= min_peak), signed compare.
    - -> UPDATE.
  - UPDATE (1 cycle):
    - If valid: sum <= sum + lag_raw - hist[wptr]; hist[wptr] <= lag_raw; wptr increments mod 2^AVG_LOG2; fill count saturates at 2^AVG_LOG2.
    - If invalid: history untouched.
    - -> PUBLISH.
  - PUBLISH (1 cycle): word loaded in a single cycle, word_valid=1, seq increments, -> IDLE.
- Latency: rise to word_valid is 4 clk cycles (edge reg, CAPTURE, UPDATE, PUBLISH).
- Sum width is IDX_W+AVG_LOG2, signed. It cannot overflow.
- avg_lag = sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
- Before the history fills, empty entries count as 0, so avg ramps toward the true value. hist_full rises in the UPDATE cycle of the 2^AVG_LOG2-th valid frame and stays high until reset.
- Value field: max_value saturated to 24-bit signed. Values > 2^23-1 give 24'h7FFFFF; values < -2^23 give 24'h800000.
- Word layout, MSB first:
  - [63:56] 8'hA5
  - [55:48] seq
  - [47:40] flags: bit0 valid, bit1 hist_full, bit2 overrun, bit3 value_saturated, others 0
  - [39:32] lag_raw
  - [31:24] avg_lag
  - [23:0] value
  - IDX_W>8 is unsupported; elaboration error.
- seq wraps 255 -> 0 and increments on every published word, valid or not.
- A rise seen in CAPTURE, UPDATE or PUBLISH is dropped and sets overrun (sticky). The in-flight frame completes normally.
- frame_done held high for many cycles produces exactly one word. A low-high toggle of 1 cycle still counts as a rise.
- word holds its value between publishes. The SPI slave may sample it at any time; the update is a single-cycle register load.
- rst asserted mid-operation returns everything to reset values immediately; no partial word is published.

Decomposition:
- Package lag_framer_pkg holds:
  - state enum {IDLE, CAPTURE, UPDATE, PUBLISH}
  - SYNC_BYTE = 8'hA5
  - flag bit index constants
  - word field offset constants
- Sub-module lag_history: circular buffer of 2^AVG_LOG2 signed entries, write pointer, fill counter, running sum. Interface: push, din, sum, full.

Test Plan:
- Reset then single frame, index=8'd140, value=32'sd10000 -> word_valid 4 cycles after rise; word = A5_00_01_0C_01_002710 (lag 12, avg 12>>>3=1).
- 8 valid frames, index=100 each (lag -28) -> hist_full high after 8th; avg_lag=8'hE4; seq 0..7.
- Frame with value=32'sd100 (< MIN_PEAK) after full history -> flags bit0=0, avg_lag unchanged, seq increments.
- Value 32'sd20000000 -> value field 24'h7FFFFF, flag bit3=1; value -32'sd9000000 -> 24'h800000.
- Second rise 2 cycles after first -> exactly one word_valid pulse, overrun=1 in the next word and remains set.
- Assert rst during UPDATE -> word=0, word_valid never pulses, seq=0. After release, 256 frames -> seq wraps to 0 on the 257th word.
